// File: rtl/uart_pkg.sv
// Shared constants for the buffered 8N1 UART transmitter:
// FSM states, 8N1 frame shape and the baud divider calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_div(
    input int clk_mhz,
    input int baud
  );
    return (clk_mhz * 1000000 + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte write port of the UART transmitter (valid/ready).
// master: wr_valid/wr_data out, wr_ready in; slave: the reverse.
interface uart_tx_buffered_if;
  import uart_pkg::*;

  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered count/flags, dout from read pointer.
// push/din write, pop/dout read; count, full, empty status.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO-fed serialiser, back-to-back frames.
// Ports: clk, rstn, wr (byte write port), fifo_count, tx_busy, uart_tx.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_MHZ    = 50,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  uart_tx_buffered_if.slave           wr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_busy,
  output logic                        uart_tx
);

  localparam int DIV = calc_div(CLK_MHZ, BAUD);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_buffered: bit period below 2 clocks");
  end

  if (STOP_BITS != 1) begin : g_stop_chk
    $error("uart_tx_buffered: only one stop bit supported");
  end

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 tick;
  logic [DATA_BITS-1:0] fifo_dout;

  assign wr.wr_ready = ~full;
  assign push        = wr.wr_valid & ~full;
  assign tick        = (cnt_q == CNT_LAST);
  assign tx_busy     = busy_q;
  assign uart_tx     = tx_q;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (wr.wr_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Line level is computed one cycle ahead so uart_tx is a flop.
  // The shifter is pre-shifted when a bit is put on the line.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          bit_d = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d = sh_q[0];
            sh_d = sh_q >> 1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: DIV=10 instance plus a 50 MHz/115200 one.
// Frame monitor compares line waveform against a scoreboard of frames.
module tb_uart_tx_buffered;

  localparam int DIV1 = 10;

  logic clk;
  logic rstn;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] cnt1;
  logic       busy1;
  logic       tx1;
  logic [4:0] cnt50;
  logic       busy50;
  logic       tx50;

  logic [9:0] sb1[$];
  int         starts1[$];

  uart_tx_buffered_if wr1();
  uart_tx_buffered_if wr50();

  uart_tx_buffered #(
    .CLK_MHZ    (1),
    .BAUD       (100000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr         (wr1),
    .fifo_count (cnt1),
    .tx_busy    (busy1),
    .uart_tx    (tx1)
  );

  uart_tx_buffered #(
    .CLK_MHZ    (50),
    .BAUD       (115200),
    .FIFO_DEPTH (16)
  ) dut50 (
    .clk        (clk),
    .rstn       (rstn),
    .wr         (wr50),
    .fifo_count (cnt50),
    .tx_busy    (busy50),
    .uart_tx    (tx50)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  // Frame monitor for the DIV=10 instance: every cycle of the frame
  // must match the expected level, and mid-bit samples give the byte.
  initial begin : mon1
    logic [9:0] exp_f;
    logic [9:0] got_f;
    int         bad_at;
    bit         abort;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && tx1 === 1'b0) begin
        starts1.push_back(cyc);
        check("sb_nonempty", 32'(sb1.size() != 0), 32'd1);
        if (sb1.size() != 0) exp_f = sb1.pop_front();
        else exp_f = '0;
        got_f  = '0;
        bad_at = -1;
        abort  = 1'b0;
        for (int c = 0; c < 10 * DIV1; c++) begin
          if (c > 0) @(negedge clk);
          if (rstn !== 1'b1) begin
            abort = 1'b1;
            break;
          end
          if (c % DIV1 == DIV1 / 2) got_f[c/DIV1] = tx1;
          if (bad_at < 0 && tx1 !== exp_f[c/DIV1]) bad_at = c;
        end
        if (!abort) begin
          check("frame_data", 32'(got_f), 32'(exp_f));
          check("frame_shape_bad_cycle", bad_at, -1);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(
    input  logic [7:0] b,
    input  logic [9:0] frame,
    output int         acc
  );
    int k = 0;
    wr1.wr_valid = 1'b1;
    wr1.wr_data  = b;
    while (wr1.wr_ready !== 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("send_ready_within_budget", 32'(k < 5000), 32'd1);
    acc = cyc;
    sb1.push_back(frame);
    @(negedge clk);
    wr1.wr_valid = 1'b0;
    wr1.wr_data  = 8'($urandom);
  endtask

  task automatic measure_busy(
    input  int budget,
    output int rise,
    output int endc
  );
    int k = 0;
    while (busy1 !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    rise = cyc;
    while (busy1 === 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    endc = cyc;
    check("busy_within_budget", 32'(k < budget), 32'd1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
    check("wait_cycle_reached", cyc, t);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    int         lat;
    int         busy_len;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    int acc;
    int acc0;
    int rise;
    int endc;
    int s;
    int badgap;
    int t0;
    int k;
    int lowlen;

    vecs[0] = '{8'hA5, 10'b1_10100101_0, 2, 100};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 2, 100};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 2, 100};
    vecs[3] = '{8'h81, 10'b1_10000001_0, 2, 100};
    vecs[4] = '{8'h5A, 10'b1_01011010_0, 2, 100};

    rstn          = 1'b0;
    wr1.wr_valid  = 1'b0;
    wr1.wr_data   = 8'h00;
    wr50.wr_valid = 1'b0;
    wr50.wr_data  = 8'h00;

    // Reset held: outputs stay at reset values, writes are ignored.
    repeat (2) @(negedge clk);
    wr1.wr_valid = 1'b1;
    wr1.wr_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_uart_tx", 32'(tx1), 32'd1);
      check("rst_wr_ready", 32'(wr1.wr_ready), 32'd1);
      check("rst_tx_busy", 32'(busy1), 32'd0);
      check("rst_fifo_count", 32'(cnt1), 32'd0);
    end
    check("rst_uart_tx_50", 32'(tx50), 32'd1);
    check("rst_fifo_count_50", 32'(cnt50), 32'd0);
    wr1.wr_valid = 1'b0;
    #1 rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle_count", 32'(cnt1), 32'd0);

    // Single frames from the table.
    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].frame, acc);
      measure_busy(400, rise, endc);
      check("single_latency", rise - acc, vecs[i].lat);
      check("single_busy_len", endc - rise, vecs[i].busy_len);
      check("single_count_after", 32'(cnt1), 32'd0);
      @(negedge clk);
    end

    // Burst of 18 bytes into a 16-deep FIFO.
    starts1.delete();
    acc0 = 0;
    for (int b = 0; b < 18; b++) begin
      send(8'(b), {1'b1, 8'(b), 1'b0}, acc);
      if (b == 0) acc0 = acc;
      if (b == 16) begin
        check("burst_count_full", 32'(cnt1), 32'd16);
        check("burst_ready_low", 32'(wr1.wr_ready), 32'd0);
      end
    end
    check("burst_stall_cycles", acc - acc0, 102);
    measure_busy(3000, rise, endc);
    check("burst_frames", starts1.size(), 18);
    badgap = 99;
    if (starts1.size() == 18) begin
      badgap = 0;
      for (int i = 1; i < 18; i++) begin
        if (starts1[i] - starts1[i-1] != 100) badgap++;
      end
      check("burst_first_start", starts1[0] - acc0, 2);
      check("burst_total", endc - starts1[0], 1800);
    end
    check("burst_bad_gaps", badgap, 0);
    check("burst_count_after", 32'(cnt1), 32'd0);
    @(negedge clk);

    // Push and pop in the same cycle during the last STOP cycle.
    starts1.delete();
    send(8'h12, 10'b1_00010010_0, acc);
    s = acc + 2;
    wait_cyc(acc + 20);
    send(8'h34, 10'b1_00110100_0, k);
    wait_cyc(s + 99);
    send(8'h56, 10'b1_01010110_0, k);
    check("pp_accept_cycle", k, s + 99);
    check("pp_count", 32'(cnt1), 32'd1);
    check("pp_next_start_tx", 32'(tx1), 32'd0);
    measure_busy(1000, rise, endc);
    check("pp_busy_end", endc, s + 300);
    if (starts1.size() >= 2) check("pp_back_to_back", starts1[1] - starts1[0], 100);
    else check("pp_frames", starts1.size(), 3);
    @(negedge clk);

    // Reset during data bit 3, then one clean frame.
    send(8'hF0, 10'b1_11110000_0, acc);
    s = acc + 2;
    send(8'h0F, 10'b1_00001111_0, k);
    wait_cyc(s + 44);
    check("mid_bit3_level", 32'(tx1), 32'd0);
    check("mid_count", 32'(cnt1), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("midrst_uart_tx", 32'(tx1), 32'd1);
    check("midrst_fifo_count", 32'(cnt1), 32'd0);
    check("midrst_tx_busy", 32'(busy1), 32'd0);
    sb1.delete();
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    starts1.delete();
    send(8'h3C, 10'b1_00111100_0, acc);
    measure_busy(400, rise, endc);
    check("midrst_clean_latency", rise - acc, 2);
    check("midrst_clean_busy_len", endc - rise, 100);
    check("midrst_frames", starts1.size(), 1);

    // Real divider on the 50 MHz instance.
    @(negedge clk);
    wr50.wr_valid = 1'b1;
    wr50.wr_data  = 8'h55;
    @(negedge clk);
    wr50.wr_valid = 1'b0;
    acc = cyc - 1;
    k = 0;
    while (tx50 !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    t0 = cyc;
    check("d50_latency", t0 - acc, 2);
    lowlen = 0;
    while (tx50 === 1'b0 && lowlen < 5000) begin
      lowlen++;
      @(negedge clk);
    end
    check("d50_start_len", lowlen, 434);
    k = 0;
    while (busy50 === 1'b1 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check("d50_frame_len", cyc - t0, 4340);
    check("d50_line_idle", 32'(tx50), 32'd1);

    repeat (5) @(negedge clk);
    check("sb_drain", sb1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
